// File: rtl/fifo_push_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_push_arbiter
//
// Shares the push port of a single FIFO between NUM_REQ producers. Once a
// producer wins, it owns the push port for a burst of up to MAX_BURST
// transfers. Ownership then rotates round-robin. A completed burst hands off
// to the next waiting producer with no bubble. An owner that drops its valid
// releases the port after that one idle cycle.
//
// Ports:
//   clk              clock, rising edge
//   rst_n            synchronous active-low reset
//   req_valid_in     per-producer valid
//   req_data_in      packed producer data, producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_grant_out    per-producer grant (combinational from push_grant_in)
//   push_valid_out   to FIFO push_valid_in
//   push_grant_in    from FIFO push_grant_out (FIFO not full)
//   push_data_out    to FIFO push_data_in
//   owner_out        current owner index, 0 when not owned
//   owner_valid_out  high while a producer owns the push port
// ---------------------------------------------------------------------------
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 17,
    parameter int MAX_BURST  = 4,
    parameter int IDX_WIDTH  = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
    output logic [NUM_REQ-1:0]            req_grant_out,
    output logic                          push_valid_out,
    input  logic                          push_grant_in,
    output logic [DATA_WIDTH-1:0]         push_data_out,
    output logic [IDX_WIDTH-1:0]          owner_out,
    output logic                          owner_valid_out
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   owner_q, owner_d;
    logic [IDX_WIDTH-1:0]   last_owner_q, last_owner_d;
    logic [CNT_WIDTH-1:0]   burst_cnt_q, burst_cnt_d;

    logic owned;
    logic owner_req;
    logic xfer;
    logic burst_done;

    // First valid requester, scanning from start and wrapping through all
    // NUM_REQ positions. The loop runs downwards so the lowest offset wins.
    function automatic logic [IDX_WIDTH-1:0] pick(input logic [NUM_REQ-1:0] valid,
                                                  input int start);
        logic [IDX_WIDTH-1:0] res;
        int idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (start + k) % NUM_REQ;
            if (valid[idx]) res = IDX_WIDTH'(idx);
        end
        return res;
    endfunction

    assign owned      = (state_q == ST_OWNED);
    assign owner_req  = req_valid_in[owner_q];
    assign xfer       = owned & owner_req & push_grant_in;
    assign burst_done = xfer && (burst_cnt_q + CNT_WIDTH'(1) == CNT_WIDTH'(MAX_BURST));

    // Output mux. Grants depend only on registered ownership and push_grant_in,
    // so there is no combinational path from req_valid_in to req_grant_out.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        req_grant_out  = '0;
        push_valid_out = 1'b0;
        push_data_out  = '0;
        if (owned) begin
            req_grant_out[owner_q] = push_grant_in;
            push_valid_out         = owner_req;
            push_data_out          = req_data_in[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign owner_out       = owned ? owner_q : '0;
    assign owner_valid_out = owned;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid_in) begin
                    owner_d     = pick(req_valid_in, int'(last_owner_q) + 1);
                    burst_cnt_d = '0;
                    state_d     = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (burst_done || !owner_req) begin
                    last_owner_d = owner_q;
                    // On an idle release the owner's bit is 0. On a completed burst it is 1.
                    // Either way, any set bit means somebody can take over at once. Scanning
                    // from owner+1 re-picks the owner only when nobody else is waiting.
                    if (|req_valid_in) begin
                        owner_d     = pick(req_valid_in, int'(owner_q) + 1);
                        burst_cnt_d = '0;
                    end else begin
                        owner_d     = '0;
                        burst_cnt_d = '0;
                        state_d     = ST_IDLE;
                    end
                end else if (xfer) begin
                    burst_cnt_d = burst_cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_WIDTH'(NUM_REQ - 1);  // first search starts at 0
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

endmodule
